// File: rtl/mpsoc_msi_wb_arbiter_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
package mpsoc_msi_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } wb_arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // Watchdog counter width; a disabled watchdog still gets a 1-bit register.
  function automatic int wdog_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/mpsoc_msi_wb_arbiter_if.sv
// Bundles the N master-side ports and the single slave-side port of the arbiter.
interface mpsoc_msi_wb_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
);

  logic [NUM_MASTERS-1:0][AW-1:0]   wbm_adr_i;
  logic [NUM_MASTERS-1:0][DW-1:0]   wbm_dat_i;
  logic [NUM_MASTERS-1:0][DW/8-1:0] wbm_sel_i;
  logic [NUM_MASTERS-1:0]           wbm_we_i;
  logic [NUM_MASTERS-1:0]           wbm_cyc_i;
  logic [NUM_MASTERS-1:0]           wbm_stb_i;
  logic [NUM_MASTERS-1:0][2:0]      wbm_cti_i;
  logic [NUM_MASTERS-1:0][1:0]      wbm_bte_i;
  logic [DW-1:0]                    wbm_dat_o;
  logic [NUM_MASTERS-1:0]           wbm_ack_o;
  logic [NUM_MASTERS-1:0]           wbm_err_o;
  logic [NUM_MASTERS-1:0]           wbm_rty_o;

  logic [AW-1:0]                    wbs_adr_o;
  logic [DW-1:0]                    wbs_dat_o;
  logic [DW/8-1:0]                  wbs_sel_o;
  logic                             wbs_we_o;
  logic                             wbs_cyc_o;
  logic                             wbs_stb_o;
  logic [2:0]                       wbs_cti_o;
  logic [1:0]                       wbs_bte_o;
  logic [DW-1:0]                    wbs_dat_i;
  logic                             wbs_ack_i;
  logic                             wbs_err_i;
  logic                             wbs_rty_i;

  logic [NUM_MASTERS-1:0]           wb_grant_o;

  // Arbiter view: serves the masters, drives the downstream slave.
  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    input  wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    output wbs_cti_o, wbs_bte_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output wb_grant_o
  );

  // Environment view: the masters and the slave surrounding the arbiter.
  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    output wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    input  wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  wb_grant_o
  );

endinterface

// File: rtl/mpsoc_msi_wb_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping to 0.
module mpsoc_msi_wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          last_grant,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   valid
);

  logic [IW-1:0] idx_s;
  logic          hit_s;

  // Scan from last_grant+1; the first hit locks out every later candidate.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx_s = '0;
    hit_s = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx_s        = IW'((int'(last_grant) + i) % NUM_MASTERS);
      hit_s        = !valid && req[idx_s];
      grant[idx_s] = grant[idx_s] | hit_s;
      valid        = valid | hit_s;
    end
  end

endmodule

// File: rtl/mpsoc_msi_wb_arbiter.sv
// N-to-1 Wishbone B3 arbiter: round-robin grant held for the whole cyc,
// with a stall watchdog that terminates hung transfers with err.
module mpsoc_msi_wb_arbiter
  import mpsoc_msi_wb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_i,
  mpsoc_msi_wb_arbiter_if.slave bus
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WW = wdog_width(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  wb_arb_state_e          state_r, state_s;
  logic [NUM_MASTERS-1:0] grant_r, grant_s;
  logic [IW-1:0]          last_grant_r, last_grant_s;
  logic [WW-1:0]          wdog_r, wdog_s;

  logic [NUM_MASTERS-1:0] rr_grant_s;
  logic                   rr_valid_s;
  logic [IW-1:0]          rr_idx_s;
  logic                   stall_s;
  logic                   granted_cyc_s;

  mpsoc_msi_wb_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_rr (
    .req        (bus.wbm_cyc_i),
    .last_grant (last_grant_r),
    .grant      (rr_grant_s),
    .valid      (rr_valid_s)
  );

  // Index of the one-hot round-robin winner.
  always_comb begin
    rr_idx_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rr_idx_s = rr_grant_s[i] ? IW'(i) : rr_idx_s;
    end
  end

  // last_grant_r doubles as the index of the current owner while a grant is held.
  assign granted_cyc_s = bus.wbm_cyc_i[last_grant_r];
  assign stall_s       = bus.wbm_stb_i[last_grant_r] &&
                         !(bus.wbs_ack_i || bus.wbs_err_i || bus.wbs_rty_i);

  // State, grant and watchdog registers.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      last_grant_r <= IW'(NUM_MASTERS - 1);
      wdog_r       <= '0;
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      wdog_r       <= wdog_s;
    end
  end

  // Next-state logic; release of cyc takes priority over a watchdog expiry.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    wdog_s       = wdog_r;
    case (state_r)
      IDLE: begin
        wdog_s = '0;
        if (rr_valid_s) begin
          state_s      = BUSY;
          grant_s      = rr_grant_s;
          last_grant_s = rr_idx_s;
        end else begin
          grant_s = '0;
        end
      end
      BUSY: begin
        if (!granted_cyc_s) begin
          state_s = IDLE;
          grant_s = '0;
          wdog_s  = '0;
        end else if ((TIMEOUT_CYCLES > 0) && stall_s) begin
          if (wdog_r >= WD_LAST) begin
            state_s = ABORT;
            wdog_s  = WD_MAX;
          end else begin
            wdog_s  = wdog_r + WW'(1);
          end
        end else begin
          wdog_s = '0;
        end
      end
      ABORT: begin
        wdog_s = '0;
        if (granted_cyc_s) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
          grant_s = '0;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
        wdog_s  = '0;
      end
    endcase
  end

  // Bus muxing: request fields from the owner, responses to the owner only.
  always_comb begin
    bus.wbm_dat_o = bus.wbs_dat_i;
    bus.wbm_ack_o = '0;
    bus.wbm_err_o = '0;
    bus.wbm_rty_o = '0;
    bus.wbs_adr_o = '0;
    bus.wbs_dat_o = '0;
    bus.wbs_sel_o = '0;
    bus.wbs_we_o  = 1'b0;
    bus.wbs_cyc_o = 1'b0;
    bus.wbs_stb_o = 1'b0;
    bus.wbs_cti_o = '0;
    bus.wbs_bte_o = '0;
    case (state_r)
      BUSY, ABORT: begin
        bus.wbs_adr_o = bus.wbm_adr_i[last_grant_r];
        bus.wbs_dat_o = bus.wbm_dat_i[last_grant_r];
        bus.wbs_sel_o = bus.wbm_sel_i[last_grant_r];
        bus.wbs_we_o  = bus.wbm_we_i[last_grant_r];
        bus.wbs_cti_o = bus.wbm_cti_i[last_grant_r];
        bus.wbs_bte_o = bus.wbm_bte_i[last_grant_r];
        if (state_r == BUSY) begin
          bus.wbs_cyc_o = granted_cyc_s;
          bus.wbs_stb_o = bus.wbm_stb_i[last_grant_r];
          bus.wbm_ack_o = grant_r & {NUM_MASTERS{bus.wbs_ack_i}};
          bus.wbm_err_o = grant_r & {NUM_MASTERS{bus.wbs_err_i}};
          bus.wbm_rty_o = grant_r & {NUM_MASTERS{bus.wbs_rty_i}};
        end else begin
          // Aborted transfer: slave cycle dropped, owner gets a one-cycle err.
          bus.wbm_err_o = grant_r;
        end
      end
      default: begin
        bus.wbm_ack_o = '0;
      end
    endcase
  end

  assign bus.wb_grant_o = grant_r;

endmodule

// File: tb/tb_mpsoc_msi_wb_arbiter.sv
// Directed, table-driven check of the 4-master arbiter with an 8-cycle watchdog.
module tb_mpsoc_msi_wb_arbiter;
  import mpsoc_msi_wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mpsoc_msi_wb_arbiter_if #(.NUM_MASTERS(4), .AW(32), .DW(32)) bus ();

  mpsoc_msi_wb_arbiter #(
    .NUM_MASTERS    (4),
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] cyc;
    logic [3:0] stb;
    logic [2:0] cti;
    logic       ack;
    logic       err;
    logic       rty;
    logic [3:0] e_grant;
    logic       e_cyc;
    logic       e_stb;
    logic [3:0] e_ack;
    logic [3:0] e_err;
    logic [3:0] e_rty;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] adr_tab[4];
  logic [31:0] dat_tab[4];
  logic [3:0]  sel_tab[4];
  logic [1:0]  bte_tab[4];
  logic [3:0]  we_mask;

  function automatic vec_t mk(input logic r, input logic [3:0] c, input logic [3:0] s,
                              input logic [2:0] t, input logic a, input logic e,
                              input logic y, input logic [3:0] eg, input logic ec,
                              input logic es, input logic [3:0] ea, input logic [3:0] ee,
                              input logic [3:0] ey);
    vec_t v;
    v.rst_n = r; v.cyc = c; v.stb = s; v.cti = t; v.ack = a; v.err = e; v.rty = y;
    v.e_grant = eg; v.e_cyc = ec; v.e_stb = es; v.e_ack = ea; v.e_err = ee; v.e_rty = ey;
    return v;
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int k);
    rst_n         = v.rst_n;
    bus.wbm_cyc_i = v.cyc;
    bus.wbm_stb_i = v.stb;
    for (int i = 0; i < 4; i++) bus.wbm_cti_i[i] = v.cti;
    bus.wbs_ack_i = v.ack;
    bus.wbs_err_i = v.err;
    bus.wbs_rty_i = v.rty;
    bus.wbs_dat_i = 32'hD000_0000 | 32'(k);
  endtask

  task automatic check_vec(input vec_t v, input int k);
    logic [31:0] e_adr, e_dat;
    logic [9:0]  e_misc;
    int          g;
    g = oh2i(v.e_grant);
    if (v.e_grant != 4'b0000) begin
      e_adr  = adr_tab[g];
      e_dat  = dat_tab[g];
      e_misc = {sel_tab[g], we_mask[g], v.cti, bte_tab[g]};
    end else begin
      e_adr  = 32'h0;
      e_dat  = 32'h0;
      e_misc = 10'h0;
    end
    chk("grant", k, 64'(bus.wb_grant_o), 64'(v.e_grant));
    chk("slave_cyc_stb", k, 64'({bus.wbs_cyc_o, bus.wbs_stb_o}), 64'({v.e_cyc, v.e_stb}));
    chk("master_resp", k, 64'({bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}),
        64'({v.e_ack, v.e_err, v.e_rty}));
    chk("slave_adr_dat", k, {bus.wbs_adr_o, bus.wbs_dat_o}, {e_adr, e_dat});
    chk("slave_sel_we_cti_bte", k,
        64'({bus.wbs_sel_o, bus.wbs_we_o, bus.wbs_cti_o, bus.wbs_bte_o}), 64'(e_misc));
    chk("read_data", k, 64'(bus.wbm_dat_o), 64'(32'hD000_0000 | 32'(k)));
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      adr_tab[i] = 32'hA000_0000 + 32'(i * 16);
      dat_tab[i] = 32'h5000_0000 + 32'(i);
      sel_tab[i] = 4'b0001 << i;
      bte_tab[i] = 2'(i);
      bus.wbm_adr_i[i] = adr_tab[i];
      bus.wbm_dat_i[i] = dat_tab[i];
      bus.wbm_sel_i[i] = sel_tab[i];
      bus.wbm_bte_i[i] = bte_tab[i];
      bus.wbm_cti_i[i] = CTI_CLASSIC;
    end
    we_mask        = 4'b0101;
    bus.wbm_we_i   = we_mask;
    bus.wbm_cyc_i  = 4'b0000;
    bus.wbm_stb_i  = 4'b0000;
    bus.wbs_ack_i  = 1'b0;
    bus.wbs_err_i  = 1'b0;
    bus.wbs_rty_i  = 1'b0;
    bus.wbs_dat_i  = 32'h0;
    rst_n          = 1'b0;

    // Reset holds off all requests.
    vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    // Single request from master 1.
    vecs.push_back(mk(1'b1, 4'b0010, 4'b0010, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0010, 4'b0010, CTI_CLASSIC, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    // Round robin 0,1,2,3,0 with an idle cycle between grants; master 2 gets rty.
    vecs.push_back(mk(1'b1, 4'b1111, 4'b1111, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b1111, CTI_CLASSIC, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1110, 4'b1110, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b1111, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b1111, CTI_CLASSIC, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1101, 4'b1101, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b1111, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b1111, CTI_CLASSIC, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0, 4'b0, 4'b0100));
    vecs.push_back(mk(1'b1, 4'b1011, 4'b1011, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b1111, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b1111, CTI_CLASSIC, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0111, 4'b0111, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0111, 4'b0111, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0111, 4'b0111, CTI_CLASSIC, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0110, 4'b0110, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    // Master 2 four-beat burst while master 0 waits.
    vecs.push_back(mk(1'b1, 4'b0100, 4'b0100, CTI_INC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b1, 4'b0101, 4'b0101, CTI_INC, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0101, 4'b0101, CTI_EOB, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0001, 4'b0001, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0001, 4'b0001, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0001, 4'b0001, CTI_CLASSIC, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    // Watchdog: 8 stalled cycles, then one abort cycle, then the count restarts.
    vecs.push_back(mk(1'b1, 4'b0010, 4'b0010, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 4'b0010, 4'b0010, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0010, 4'b0010, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0, 4'b0010, 4'b0));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(1'b1, 4'b0010, 4'b0010, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0010, 4'b0010, CTI_CLASSIC, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0, 4'b0010, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    // Owner drops cyc together with its ack while master 3 waits.
    vecs.push_back(mk(1'b1, 4'b0100, 4'b0100, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1100, 4'b1100, CTI_CLASSIC, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1000, 4'b1000, CTI_CLASSIC, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1000, 4'b1000, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b1000, 4'b1000, CTI_CLASSIC, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, CTI_CLASSIC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0));

    repeat (2) @(posedge clk);
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k], k);
      #1;
      check_vec(vecs[k], k);
    end

    // Reset in the middle of a master-2 burst; afterwards master 0 beats master 3.
    @(negedge clk);
    v = mk(1'b1, 4'b0100, 4'b0100, CTI_INC, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0);
    drive(v, 1000);
    #1;
    chk("rst_burst_idle_grant", 0, 64'(bus.wb_grant_o), 64'(4'b0000));
    @(negedge clk);
    bus.wbs_ack_i = 1'b1;
    #1;
    chk("rst_burst_beat1_grant", 1, 64'(bus.wb_grant_o), 64'(4'b0100));
    chk("rst_burst_beat1_ack", 1, 64'(bus.wbm_ack_o), 64'(4'b0100));
    @(negedge clk);
    rst_n         = 1'b0;
    bus.wbm_cyc_i = 4'b1101;
    bus.wbm_stb_i = 4'b1101;
    #1;
    chk("rst_burst_beat2_ack", 2, 64'(bus.wbm_ack_o), 64'(4'b0100));
    @(negedge clk);
    rst_n         = 1'b1;
    bus.wbs_ack_i = 1'b0;
    #1;
    chk("rst_burst_after_grant", 3, 64'(bus.wb_grant_o), 64'(4'b0000));
    chk("rst_burst_after_cyc", 3, 64'({bus.wbs_cyc_o, bus.wbs_stb_o}), 64'(2'b00));
    @(negedge clk);
    #1;
    chk("rst_first_winner", 4, 64'(bus.wb_grant_o), 64'(4'b0001));
    chk("rst_first_winner_adr", 4, 64'({bus.wbs_cyc_o, bus.wbs_adr_o}), 64'({1'b1, adr_tab[0]}));
    @(negedge clk);
    bus.wbm_cyc_i = 4'b0000;
    bus.wbm_stb_i = 4'b0000;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpsoc_msi_wb_arbiter.md
Name: mpsoc_msi_wb_arbiter

Overview:
N-master to 1-slave Wishbone B3 arbiter that sits directly upstream of mpsoc_msi_wb_mux and drives its master port. It grants one master at a time, round-robin. The grant is held for the whole bus cycle (cyc), so classic and incrementing bursts are never split. A per-cycle watchdog aborts stalled transfers with err.

Parameters:
NUM_MASTERS, 2, number of requesting masters (>=2)
AW, 32, address width
DW, 32, data width; sel width is DW/8
TIMEOUT_CYCLES, 256, stall cycles before forced err; 0 disables the watchdog

Ports:
wb_clk_i  in  1  bus clock, all logic on rising edge
wb_rst_i  in  1  synchronous reset, active-low (0 = reset)
wbm_adr_i  in  [NUM_MASTERS-1:0][AW-1:0]  master addresses
wbm_dat_i  in  [NUM_MASTERS-1:0][DW-1:0]  master write data
wbm_sel_i  in  [NUM_MASTERS-1:0][DW/8-1:0]  byte selects
wbm_we_i / wbm_cyc_i / wbm_stb_i  in  [NUM_MASTERS-1:0]  per-master control
wbm_cti_i  in  [NUM_MASTERS-1:0][2:0]  cycle type
wbm_bte_i  in  [NUM_MASTERS-1:0][1:0]  burst type
wbm_dat_o  out  DW  read data, broadcast to all masters
wbm_ack_o / wbm_err_o / wbm_rty_o  out  [NUM_MASTERS-1:0]  per-master responses
wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  slave-side request (widths AW, DW, DW/8, 1, 1, 1, 3, 2)
wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  slave-side response (DW, 1, 1, 1)
wb_grant_o  out  NUM_MASTERS  registered one-hot grant, 0 when idle

Behaviour:
- Reset (wb_rst_i==0 at an edge): state IDLE, wb_grant_o=0, last_grant=NUM_MASTERS-1 (master 0 wins first), watchdog=0. Reset mid-burst drops the grant at that edge; wbs_cyc_o/wbs_stb_o are 0 from the following cycle.
- Slave-side outputs while idle: wbs_cyc_o=0, wbs_stb_o=0, wbs_we_o=0, other request fields 0.
- Master responses while idle: wbm_ack_o/err_o/rty_o=0.
- FSM IDLE: if any wbm_cyc_i is set, select the first requester scanning from last_grant+1 with wrap to 0. Register it into wb_grant_o and last_grant, then go to BUSY. Arbitration latency is 1 cycle: the slave sees the request the cycle after cyc was first sampled.
- FSM BUSY: wbs_* request fields mux combinationally from the granted master. wbs_ack/err/rty route combinationally to the granted master only; non-granted masters see 0. wbm_dat_o = wbs_dat_i always.
- Release: at the first edge where the granted wbm_cyc_i==0, go to IDLE and clear wb_grant_o. There is always one idle cycle between grants (no same-edge regrant).
- A response coincident with the granted master dropping cyc is still forwarded that cycle.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counts in BUSY while granted stb==1 and no ack/err/rty.
  - Clears on any response, on stb==0, or on leaving BUSY.
  - When the count reaches TIMEOUT_CYCLES: the next cycle is an ABORT state. In ABORT, wbm_err_o[granted]=1 for exactly 1 cycle, wbs_cyc_o=0, wbs_stb_o=0, and the counter clears.
  - Leaving ABORT: return to BUSY if granted cyc is still 1, else go to IDLE.
- Counter width: $clog2(TIMEOUT_CYCLES+1), saturating; it never wraps.
- Only the granted master's cyc is monitored. Other masters' cyc/stb toggles are ignored until IDLE.

Decomposition:
- Package mpsoc_msi_wb_pkg: state enum {IDLE, BUSY, ABORT}, CTI/BTE localparams (CTI_CLASSIC=3'b000, CTI_INC=3'b010, CTI_EOB=3'b111).
- Sub-module mpsoc_msi_wb_rr_arbiter: combinational round-robin pick. Inputs: request vector and last_grant. Outputs: one-hot next grant and valid. Parameter: NUM_MASTERS.

Test Plan:
- Single request: master 1 raises cyc/stb at cycle 0 -> wbs_cyc_o=1 at cycle 1, wb_grant_o=4'b0010 (NUM_MASTERS=4), slave ack reaches wbm_ack_o[1] only.
- Round-robin: all 4 masters hold cyc continuously, each doing one single transfer -> grant order 0,1,2,3,0, with one idle cycle between grants.
- Burst hold: master 2 runs a 4-beat CTI_INC burst ending in CTI_EOB while master 0 requests -> master 0 is not granted until 1 cycle after master 2 drops cyc; all 4 acks go to master 2.
- Timeout: TIMEOUT_CYCLES=8, slave never acks -> wbm_err_o[granted] pulses for 1 cycle 9 cycles after stb rises, wbs_cyc_o=0 that cycle, and the counter restarts.
- Reset mid-burst: wb_rst_i=0 during beat 2 -> wb_grant_o=0 and wbs_cyc_o=0 next cycle; after release, master 0 wins first arbitration.
- Simultaneous release and request: the granted master drops cyc in the same cycle its ack arrives, while master 3 requests -> ack is forwarded, and master 3 is granted 2 edges later.
